// File: rtl/mole_sched.sv
// Whack-a-mole sequencer: walks IDLE/WAIT/POP/HIT on a slow tick, raises one
// pseudo-random mole at a time, and classifies player hits as correct or wrong.
module mole_sched #(
  parameter int         WAIT_TICKS = 4,
  parameter int         POP_TICKS  = 8,
  parameter int         HIT_TICKS  = 2,
  parameter int         ROUNDS     = 20,
  parameter logic [3:0] LFSR_SEED  = 4'h9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] hamster_hit,
  output logic [1:0] state,
  output logic [9:0] hamster_led,
  output logic       hit_ok,
  output logic       miss,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POP  = 2'b01,
    HIT  = 2'b10,
    WAIT = 2'b11
  } state_t;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [3:0] SEED     = (LFSR_SEED == 4'h0) ? 4'h1 : LFSR_SEED;
  localparam logic [8:0] WAIT_LEN = 9'(WAIT_TICKS);
  localparam logic [8:0] POP_LEN  = 9'(POP_TICKS);
  localparam logic [8:0] HIT_LEN  = 9'(HIT_TICKS);
  localparam logic [6:0] LAST     = 7'(ROUNDS);

  state_t     st_reg;
  logic [7:0] cnt_reg;
  logic [6:0] round_reg;
  logic [3:0] lfsr_reg;

  logic [8:0] cnt_inc;
  logic [8:0] phase_len;
  logic       expired;
  logic [3:0] hole;
  logic [6:0] round_inc;
  logic       last_round;

  assign cnt_inc    = {1'b0, cnt_reg} + 9'd1;
  assign round_inc  = round_reg + 7'd1;
  assign last_round = (round_inc == LAST);
  assign hole       = (lfsr_reg < 4'd10) ? lfsr_reg : lfsr_reg - 4'd10;
  assign state      = st_reg;

  always_comb begin
    phase_len = POP_LEN;
    case (st_reg)
      WAIT:    phase_len = WAIT_LEN;
      HIT:     phase_len = HIT_LEN;
      default: phase_len = POP_LEN;
    endcase
  end

  // ">=" rather than "==": a wrong hit on the expiring tick still advances the
  // counter, and the mole must then escape on the following tick.
  assign expired = tick && (cnt_inc >= phase_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_reg      <= IDLE;
      cnt_reg     <= 8'd0;
      round_reg   <= 7'd0;
      lfsr_reg    <= SEED;
      hamster_led <= 10'd0;
      hit_ok      <= 1'b0;
      miss        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      lfsr_reg  <= {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
      hit_ok    <= 1'b0;
      miss      <= 1'b0;
      game_over <= 1'b0;
      if (tick) cnt_reg <= cnt_inc[7:0];

      case (st_reg)
        IDLE: begin
          if (start) begin
            st_reg    <= WAIT;
            round_reg <= 7'd0;
            cnt_reg   <= 8'd0;
          end
        end
        WAIT: begin
          if (expired) begin
            st_reg      <= POP;
            hamster_led <= 10'(1) << hole;
            cnt_reg     <= 8'd0;
          end
        end
        POP: begin
          if (|(hamster_hit & hamster_led)) begin
            st_reg      <= HIT;
            hit_ok      <= 1'b1;
            hamster_led <= 10'd0;
            cnt_reg     <= 8'd0;
          end else if (|hamster_hit) begin
            miss <= 1'b1;
          end else if (expired) begin
            miss        <= 1'b1;
            hamster_led <= 10'd0;
            round_reg   <= round_inc;
            cnt_reg     <= 8'd0;
            st_reg      <= last_round ? IDLE : WAIT;
            game_over   <= last_round;
          end
        end
        HIT: begin
          if (expired) begin
            round_reg <= round_inc;
            cnt_reg   <= 8'd0;
            st_reg    <= last_round ? IDLE : WAIT;
            game_over <= last_round;
          end
        end
        default: st_reg <= IDLE;
      endcase
    end
  end

endmodule
